// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the rl_ram family: clear-engine FSM states and
// the read-latency rule used to size the valid pipeline.
package rl_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rl_state_e;

    function automatic int rd_latency(input bit reg_out);
        return reg_out ? 2 : 1;
    endfunction

endpackage

// File: rtl/rl_ram_1rw.sv
// Single-port 1RW memory array with bit-granular byte-enable writes and a
// registered read port; TECHNOLOGY selects the implementation.
module rl_ram_1rw #(
    parameter int ABITS      = 10,
    parameter int DBITS      = 32,
    parameter     TECHNOLOGY = "GENERIC"
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [(DBITS+7)/8-1:0]   be,
    input  logic [ABITS-1:0]         addr,
    input  logic [DBITS-1:0]         din,
    output logic [DBITS-1:0]         dout
);

    logic [DBITS-1:0] mem [2**ABITS];

    // NOTE: the array has no reset; contents are established by the clear
    // engine in the wrapper, so a reset port here would only cost routing.
    if (TECHNOLOGY == "GENERIC") begin : g_generic
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    for (int i = 0; i < DBITS; i++) begin
                        if (be[i/8]) mem[addr][i] <= din[i];
                    end
                end else begin
                    dout <= mem[addr];
                end
            end
        end
    end else begin : g_fallback
        // No vendor macro is mapped for this technology yet; use the same
        // behavioural array so the wrapper still elaborates and simulates.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    for (int i = 0; i < DBITS; i++) begin
                        if (be[i/8]) mem[addr][i] <= din[i];
                    end
                end else begin
                    dout <= mem[addr];
                end
            end
        end
    end

endmodule

// File: rtl/rl_ram_1rw_clr.sv
// 1RW RAM with a sweep engine that writes INIT_VAL to every entry after reset
// or on clr, plus request rejection and a latency-matched read-valid strobe.
module rl_ram_1rw_clr
    import rl_ram_pkg::*;
#(
    parameter int               ABITS      = 10,
    parameter int               DBITS      = 32,
    parameter int               DEPTH      = 2**ABITS,
    parameter logic [DBITS-1:0] INIT_VAL   = '0,
    parameter bit               REG_OUT    = 1'b0,
    parameter                   TECHNOLOGY = "GENERIC"
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   req,
    input  logic [ABITS-1:0]       addr,
    input  logic                   we,
    input  logic [(DBITS+7)/8-1:0] be,
    input  logic [DBITS-1:0]       din,
    output logic [DBITS-1:0]       dout,
    output logic                   dout_vld,
    output logic                   busy,
    output logic                   rej
);

    localparam int               LAT     = rd_latency(REG_OUT);
    localparam logic [ABITS:0]   LAST    = (ABITS+1)'(DEPTH - 1);
    localparam logic [ABITS:0]   DEPTH_W = (ABITS+1)'(DEPTH);

    rl_state_e        state;
    logic [ABITS:0]   cnt;
    logic             accept;
    logic             rd_acc;
    logic [LAT-1:0]   vld_sr;

    logic                   mem_en;
    logic                   mem_we;
    logic [(DBITS+7)/8-1:0] mem_be;
    logic [ABITS-1:0]       mem_addr;
    logic [DBITS-1:0]       mem_din;
    logic [DBITS-1:0]       mem_dout;

    assign busy   = (state == CLEAR);
    assign accept = req & ~busy & ({1'b0, addr} < DEPTH_W);
    assign rd_acc = accept & ~we;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            cnt   <= '0;
            rej   <= 1'b0;
        end else begin
            rej <= req & ~accept;
            unique case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Any access this cycle completes; the sweep starts next cycle.
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // The sweep owns the array while busy; otherwise the client port does.
    assign mem_en   = busy | accept;
    assign mem_we   = busy | we;
    assign mem_be   = busy ? '1 : be;
    assign mem_addr = busy ? cnt[ABITS-1:0] : addr;
    assign mem_din  = busy ? INIT_VAL : din;

    rl_ram_1rw #(
        .ABITS      (ABITS),
        .DBITS      (DBITS),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_ram (
        .clk  (clk),
        .en   (mem_en),
        .we   (mem_we),
        .be   (mem_be),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (mem_dout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_sr <= '0;
        else       vld_sr <= LAT'({vld_sr, rd_acc});
    end

    assign dout_vld = vld_sr[LAT-1];

    if (REG_OUT) begin : g_reg_out
        logic [DBITS-1:0] dout_q;
        // Capture only on a returning read so the output holds between reads.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)          dout_q <= '0;
            else if (vld_sr[0]) dout_q <= mem_dout;
        end
        assign dout = dout_q;
    end else begin : g_raw_out
        assign dout = mem_dout;
    end

endmodule

// File: doc/rl_ram_1rw_clr.md
# rl_ram_1rw_clr

Single-port (1RW) RAM with a built-in clear engine and optional output register. Sweeps every entry to a programmable value after reset or on request, reports busy/reject status, and adds a read-valid strobe so clients need not track read latency. Sits wherever a 1RW array must start from a known state, such as tag/valid arrays and scoreboards, and instantiates the technology-selecting `rl_ram_1rw` internally.

## Interface
- `ABITS`, 10, address width.
- `DBITS`, 32, data width; byte enables are `(DBITS+7)/8` wide.
- `DEPTH`, `2**ABITS`, number of valid entries; must satisfy `1 <= DEPTH <= 2**ABITS`.
- `INIT_VAL`, `'0`, DBITS-wide value written to every entry during a clear.
- `REG_OUT`, 0, 1 adds an output register, giving a read latency of 2 instead of 1.
- `TECHNOLOGY`, "GENERIC", passed to the memory array unchanged.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  single-cycle request to re-clear the whole array.
- `req`  in  1  access request, sampled every cycle.
- `addr`  in  ABITS  access address.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `be`  in  (DBITS+7)/8  byte enables for writes.
- `din`  in  DBITS  write data.
- `dout`  out  DBITS  read data; meaningful only while `dout_vld` = 1.
- `dout_vld`  out  1  one-cycle strobe marking valid read data.
- `busy`  out  1  high while a clear sweep is in progress.
- `rej`  out  1  one-cycle strobe: the previous cycle's `req` was dropped.

## Operation
- FSM has two states, CLEAR and RUN; reset enters CLEAR with the sweep counter `cnt` = 0.
- **CLEAR state:**
  - Each cycle, write `INIT_VAL` to entry `cnt` with all byte enables set, then increment `cnt`.
  - After writing `DEPTH-1`, go to RUN.
  - `busy` = 1 throughout CLEAR.
- **`clr` while in CLEAR:** reset `cnt` to 0 and restart the sweep; the entry at the current `cnt` is still written that cycle.
- **`clr` while in RUN:** go to CLEAR with `cnt` = 0. If `req` is also high that cycle, the access completes first; the sweep starts next cycle.
- **RUN state:**
  - `req & we` writes `din` to `addr`, honouring `be`.
  - `req & ~we` reads `addr`.
  - Writes never produce `dout_vld`.
- **Rejection:** `req` is dropped when `busy` = 1 or `addr >= DEPTH`. A dropped request causes no memory access and `rej` = 1 on the next cycle. No other response is generated.
- **Entries above `DEPTH`:** addresses `DEPTH .. 2**ABITS-1` are never written.
- **Reset mid-sweep:** restarts the sweep from 0.
- **Read-during-clear ordering:** a read accepted in the last RUN cycle before a `clr` still returns its data with `dout_vld`.

## Timing
- **Clear sweep:** takes exactly `DEPTH` cycles. `busy` falls on the edge after the write to `DEPTH-1`, so the first access can be accepted in the cycle where `busy` = 0.
- **Read latency:**
  - `REG_OUT` = 0: `dout_vld` and `dout` appear 1 cycle after an accepted read.
  - `REG_OUT` = 1: they appear 2 cycles after, and `dout` holds its value between reads.
- **Throughput:** one access per cycle in RUN, with no bubbles between back-to-back reads and writes.
- **Read after write:** a read issued the cycle after a write to the same address returns the new data.
- **Reset values:**
  - `busy` = 1, `dout_vld` = 0, `rej` = 0, `cnt` = 0.
  - `dout` = 0 when `REG_OUT` = 1; undefined until the first read when `REG_OUT` = 0.
- **Counter width:** `cnt` is `ABITS+1` bits so that `DEPTH = 2**ABITS` compares without wrap-around.

## Structure
- Package `rl_ram_pkg` holds the FSM state typedef (`CLEAR`, `RUN`) and the latency helper function `rd_latency(REG_OUT)`.
- One sub-module: `rl_ram_1rw`, which receives `ABITS`, `DBITS` and `TECHNOLOGY`.
- Address, write-enable, byte-enable and data muxes select between the sweep engine and the client port in front of the array.
- Valid/latency pipeline is a `rd_latency`-deep shift register.

## Test plan
- **Reset sweep:** `DEPTH` = 16, `INIT_VAL` = 32'hA5A5_A5A5; release reset -> `busy` = 1 for exactly 16 cycles; then reads of addresses 0–15 all return A5A5_A5A5 with `dout_vld` 1 cycle later.
- **Byte-enable write:** write 32'h1122_3344 to address 3 with `be` = 4'b0101 -> a read of address 3 returns 32'hA522_A544.
- **Mid-sweep `clr`:** assert `clr` at sweep cycle 10 -> `busy` stays high for 10 + 16 cycles in total; afterwards all entries equal `INIT_VAL`.
- **Rejected requests:** `req` while `busy` = 1, or with `addr` = 16 when `DEPTH` = 16 -> `rej` = 1 one cycle later, no `dout_vld`, and memory contents unchanged.
- **`REG_OUT` = 1 back-to-back reads:** reads to addresses 1, 2, 3 on consecutive cycles -> three consecutive `dout_vld` pulses starting 2 cycles after the first read, carrying the correct data.
- **Same-cycle `clr` and read:** a read of address 5 in the same cycle as `clr` in RUN -> the read data is returned with `dout_vld`, then `busy` rises and a full sweep follows.
